// File: rtl/pixel_framebuffer.sv
// ---------------------------------------------------------------------------
// pixel_framebuffer
//
// 1-bit-per-cell framebuffer between the VGA scan-out generator and the
// machine core. 80x60 cells, each cell covers 8x8 screen pixels.
//
// Read port (scan-out, independent of the write side):
//   x, y, rdn -> px   registered, one cycle latency. px is 0 when rdn was
//                     low or the scan position is outside 640x480.
//
// Write port (machine core):
//   wr_valid/wr_ready handshake. A command transfers on a clock edge where
//   wr_valid and wr_ready are both high; the core must hold wr_x/wr_y/wr_op
//   stable while wr_valid is high and not yet accepted. wr_ready depends only
//   on the FSM state, never on wr_valid.
//   wr_op: 0=nop, 1=set, 2=clear, 3=toggle.
//   wr_done pulses one cycle after the command executes; wr_collision is
//   valid with it (toggle of a cell that was 1).
//
// Clear engine (built only when FB_CLEAR_EN is defined):
//   clr_req pulse wipes all 4800 cells, one per cycle, busy high meanwhile.
//   Reset also starts a clear. Without FB_CLEAR_EN, clr_req is ignored,
//   busy is 0 and the array is not initialised by reset.
//
// dbg_state exposes the FSM state (0=IDLE, 1=EXEC, 2=CLEAR).
//
// Clock clk_25mhz, reset synchronous active-high.
// ---------------------------------------------------------------------------
module pixel_framebuffer #(
  parameter int CELL_W      = 80,
  parameter int CELL_H      = 60,
  parameter int SCALE_SHIFT = 3
) (
  input  logic       clk_25mhz,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [8:0] y,
  input  logic       rdn,
  output logic       px,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [6:0] wr_x,
  input  logic [5:0] wr_y,
  input  logic [1:0] wr_op,
  output logic       wr_done,
  output logic       wr_collision,
  input  logic       clr_req,
  output logic       busy,
  output logic [1:0] dbg_state
);

  localparam int DEPTH = CELL_W * CELL_H;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
`ifdef FB_CLEAR_EN
  localparam logic [1:0] ST_CLEAR = 2'd2;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
`endif

  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_SET = 2'd1;
  localparam logic [1:0] OP_CLR = 2'd2;
  localparam logic [1:0] OP_TOG = 2'd3;

  logic mem_q [DEPTH];

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    op_q, op_d;
  logic          old_q, old_d;
  logic          inr_q, inr_d;
  logic          done_q, done_d;
  logic          coll_q, coll_d;
  logic          px_q, px_d;
`ifdef FB_CLEAR_EN
  logic          pend_q, pend_d;
  logic [AW-1:0] cnt_q, cnt_d;
`else
  logic          unused_clr_req;
  assign unused_clr_req = clr_req;
`endif

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic          mem_wdata;

  logic          wr_in_range;
  logic [AW-1:0] wr_addr;
  logic          rd_in_range;
  logic [AW-1:0] rd_addr;
  logic          hs;

  // Out-of-range addresses are forced to 0 so the array is never indexed
  // past its end; the in-range flag suppresses their effect.
  always_comb begin
    wr_in_range = (int'(wr_x) < CELL_W) && (int'(wr_y) < CELL_H);
    wr_addr     = '0;
    if (wr_in_range) wr_addr = AW'(int'(wr_y) * CELL_W + int'(wr_x));

    rd_in_range = rdn && (int'(x) < (CELL_W << SCALE_SHIFT))
                      && (int'(y) < (CELL_H << SCALE_SHIFT));
    rd_addr     = '0;
    if (rd_in_range)
      rd_addr = AW'((int'(y) >> SCALE_SHIFT) * CELL_W + (int'(x) >> SCALE_SHIFT));
    px_d = rd_in_range & mem_q[rd_addr];
  end

  assign wr_ready = (state_q == ST_IDLE);
  assign hs       = wr_valid && wr_ready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    op_d      = op_q;
    old_d     = old_q;
    inr_d     = inr_q;
    done_d    = 1'b0;
    coll_d    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = 1'b0;
`ifdef FB_CLEAR_EN
    pend_d    = pend_q;
    cnt_d     = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          addr_d  = wr_addr;
          op_d    = wr_op;
          inr_d   = wr_in_range;
          old_d   = mem_q[wr_addr];
          state_d = ST_EXEC;
`ifdef FB_CLEAR_EN
          // A clear arriving with a command waits until the command is done.
          pend_d  = clr_req;
        end else if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
`endif
        end
      end
      ST_EXEC: begin
        mem_we  = inr_q && (op_q != OP_NOP);
        case (op_q)
          OP_SET:  mem_wdata = 1'b1;
          OP_CLR:  mem_wdata = 1'b0;
          OP_TOG:  mem_wdata = ~old_q;
          default: mem_wdata = old_q;
        endcase
        done_d  = 1'b1;
        coll_d  = inr_q && (op_q == OP_TOG) && old_q;
        state_d = ST_IDLE;
`ifdef FB_CLEAR_EN
        if (pend_q) begin
          state_d = ST_CLEAR;
          pend_d  = 1'b0;
          cnt_d   = '0;
        end
`endif
      end
`ifdef FB_CLEAR_EN
      ST_CLEAR: begin
        // clr_req is not looked at here, so a new request cannot restart it.
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = 1'b0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
`ifdef FB_CLEAR_EN
      state_q <= ST_CLEAR;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
`else
      state_q <= ST_IDLE;
`endif
      addr_q  <= '0;
      op_q    <= OP_NOP;
      old_q   <= 1'b0;
      inr_q   <= 1'b0;
      done_q  <= 1'b0;
      coll_q  <= 1'b0;
      px_q    <= 1'b0;
    end else begin
      state_q <= state_d;
`ifdef FB_CLEAR_EN
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
`endif
      addr_q  <= addr_d;
      op_q    <= op_d;
      old_q   <= old_d;
      inr_q   <= inr_d;
      done_q  <= done_d;
      coll_q  <= coll_d;
      px_q    <= px_d;
    end
  end

  // Array has no reset; a write in a reset cycle is dropped so reset aborts
  // whatever operation was in flight.
  always_ff @(posedge clk_25mhz) begin
    if (!reset && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign px           = px_q;
  assign wr_done      = done_q;
  assign wr_collision = coll_q;
  assign dbg_state    = state_q;
`ifdef FB_CLEAR_EN
  assign busy         = (state_q == ST_CLEAR);
`else
  assign busy         = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_framebuffer.sv
// ---------------------------------------------------------------------------
// tb_pixel_framebuffer: directed testbench for pixel_framebuffer.
// Clear-engine sequences are compiled in when FB_CLEAR_EN is defined.
// ---------------------------------------------------------------------------
module tb_pixel_framebuffer;

  logic       clk_25mhz;
  logic       reset;
  logic [9:0] x;
  logic [8:0] y;
  logic       rdn;
  logic       px;
  logic       wr_valid;
  logic       wr_ready;
  logic [6:0] wr_x;
  logic [5:0] wr_y;
  logic [1:0] wr_op;
  logic       wr_done;
  logic       wr_collision;
  logic       clr_req;
  logic       busy;
  logic [1:0] dbg_state;

  pixel_framebuffer dut (
    .clk_25mhz    (clk_25mhz),
    .reset        (reset),
    .x            (x),
    .y            (y),
    .rdn          (rdn),
    .px           (px),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_x         (wr_x),
    .wr_y         (wr_y),
    .wr_op        (wr_op),
    .wr_done      (wr_done),
    .wr_collision (wr_collision),
    .clr_req      (clr_req),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk_25mhz = 1'b0;
  always #20 clk_25mhz = ~clk_25mhz;

  int n_cmp = 0;
  int n_err = 0;

  // expected wr_collision for every command still to complete
  logic [0:0] exp_q[$];

  initial begin
    #3600000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk_25mhz);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Scoreboard: every completion is matched against the oldest expectation.
  always @(negedge clk_25mhz) begin
    if (!reset && wr_done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got wr_done=1 expected no completion");
      end else begin
        check("collision", {31'b0, wr_collision}, {31'b0, exp_q.pop_front()});
      end
    end
  end

  task automatic wait_ready();
    int guard = 0;
    while (!wr_ready && guard < 10000) begin
      tick();
      guard++;
    end
    check("ready_wait", {31'b0, wr_ready}, 1);
  endtask

  // One command through the handshake; checks EXEC/done timing.
  task automatic do_cmd(input logic [6:0] cx, input logic [5:0] cy,
                        input logic [1:0] op, input logic exp_coll);
    wait_ready();
    wr_valid = 1'b1;
    wr_x     = cx;
    wr_y     = cy;
    wr_op    = op;
    exp_q.push_back(exp_coll);
    tick();                     // handshake edge, now in EXEC
    wr_valid = 1'b0;
    check("exec_ready_low", {31'b0, wr_ready}, 0);
    check("exec_no_done", {31'b0, wr_done}, 0);
    tick();                     // handshake cycle + 2
    check("done_lat2", {31'b0, wr_done}, 1);
    check("ready_back", {31'b0, wr_ready}, 1);
  endtask

  task automatic rd_check(input string name, input logic [9:0] rx, input logic [8:0] ry,
                          input logic ren, input logic exp);
    x   = rx;
    y   = ry;
    rdn = ren;
    tick();
    check(name, {31'b0, px}, {31'b0, exp});
    rdn = 1'b0;
  endtask

`ifdef FB_CLEAR_EN
  // Counts cycles with busy high, starting in a cycle already known to be busy.
  task automatic count_busy(input string name);
    int cyc = 0;
    while (busy && cyc < 6000) begin
      tick();
      cyc++;
    end
    check(name, cyc, 4800);
    check({name, "_ready"}, {31'b0, wr_ready}, 1);
  endtask
`endif

  typedef struct {
    logic [9:0] x;
    logic [8:0] y;
    logic       rdn;
    logic       exp_px;
  } rd_vec_t;

  rd_vec_t rd_tab[12];

  // ---------------- test ----------------
  initial begin
    reset    = 1'b1;
    x        = '0;
    y        = '0;
    rdn      = 1'b0;
    wr_valid = 1'b0;
    wr_x     = '0;
    wr_y     = '0;
    wr_op    = '0;
    clr_req  = 1'b0;

    // Cell (12,7) covers x=96..103, y=56..63; neighbours are cleared first.
    rd_tab[0]  = '{10'd96,  9'd56,  1'b1, 1'b1};
    rd_tab[1]  = '{10'd103, 9'd56,  1'b1, 1'b1};
    rd_tab[2]  = '{10'd96,  9'd63,  1'b1, 1'b1};
    rd_tab[3]  = '{10'd103, 9'd63,  1'b1, 1'b1};
    rd_tab[4]  = '{10'd100, 9'd60,  1'b1, 1'b1};
    rd_tab[5]  = '{10'd95,  9'd60,  1'b1, 1'b0};
    rd_tab[6]  = '{10'd104, 9'd60,  1'b1, 1'b0};
    rd_tab[7]  = '{10'd100, 9'd55,  1'b1, 1'b0};
    rd_tab[8]  = '{10'd100, 9'd64,  1'b1, 1'b0};
    rd_tab[9]  = '{10'd100, 9'd60,  1'b0, 1'b0};
    rd_tab[10] = '{10'd640, 9'd56,  1'b1, 1'b0};
    rd_tab[11] = '{10'd96,  9'd480, 1'b1, 1'b0};

    do_reset();
    check("rst_px", {31'b0, px}, 0);
    check("rst_done", {31'b0, wr_done}, 0);
    check("rst_coll", {31'b0, wr_collision}, 0);

`ifdef FB_CLEAR_EN
    check("rst_busy", {31'b0, busy}, 1);
    check("rst_ready_low", {31'b0, wr_ready}, 0);
    count_busy("rst_clear_len");
    begin
      int ones = 0;
      for (int cy = 0; cy < 60; cy++) begin
        for (int cx = 0; cx < 80; cx++) begin
          x   = 10'((cx << 3) + (cx % 8));
          y   = 9'((cy << 3) + (cy % 8));
          rdn = 1'b1;
          tick();
          if (px) ones++;
        end
      end
      rdn = 1'b0;
      check("rst_all_zero", ones, 0);
    end
`else
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_ready", {31'b0, wr_ready}, 1);
`endif

    // Known state around the cell under test.
    do_cmd(7'd11, 6'd7, 2'd2, 1'b0);
    do_cmd(7'd13, 6'd7, 2'd2, 1'b0);
    do_cmd(7'd12, 6'd6, 2'd2, 1'b0);
    do_cmd(7'd12, 6'd8, 2'd2, 1'b0);
    do_cmd(7'd0,  6'd1, 2'd2, 1'b0);
    do_cmd(7'd12, 6'd7, 2'd1, 1'b0);

    for (int i = 0; i < 12; i++) begin
      x   = rd_tab[i].x;
      y   = rd_tab[i].y;
      rdn = rd_tab[i].rdn;
      tick();
      check($sformatf("rd_tab%0d", i), {31'b0, px}, {31'b0, rd_tab[i].exp_px});
    end
    rdn = 1'b0;

    // Toggle twice: 1 -> 0 with collision, 0 -> 1 without.
    do_cmd(7'd12, 6'd7, 2'd3, 1'b1);
    rd_check("tog1_val", 10'd100, 9'd60, 1'b1, 1'b0);
    do_cmd(7'd12, 6'd7, 2'd3, 1'b0);
    rd_check("tog2_val", 10'd100, 9'd60, 1'b1, 1'b1);

    // Nop leaves the cell alone; toggle of a 0 cell is not a collision.
    do_cmd(7'd12, 6'd7, 2'd0, 1'b0);
    rd_check("nop_val", 10'd100, 9'd60, 1'b1, 1'b1);
    do_cmd(7'd11, 6'd7, 2'd3, 1'b0);
    rd_check("tog0_val", 10'd88, 9'd56, 1'b1, 1'b1);

    // Out-of-range commands complete but write nothing.
    do_cmd(7'd80, 6'd0, 2'd1, 1'b0);
    do_cmd(7'd80, 6'd0, 2'd3, 1'b0);
    do_cmd(7'd5, 6'd60, 2'd1, 1'b0);
    rd_check("oor_cell01", 10'd0, 9'd8, 1'b1, 1'b0);

    // Read of the written cell during EXEC returns the old value.
    wait_ready();
    wr_valid = 1'b1;
    wr_x = 7'd12; wr_y = 6'd7; wr_op = 2'd2;
    exp_q.push_back(1'b0);
    x = 10'd100; y = 9'd60; rdn = 1'b1;
    tick();
    wr_valid = 1'b0;
    check("pre_exec_px", {31'b0, px}, 1);
    tick();
    check("no_bypass_px", {31'b0, px}, 1);
    tick();
    check("after_write_px", {31'b0, px}, 0);
    rdn = 1'b0;

    // Back-to-back: wr_valid held, ready alternates, handshakes 2 cycles apart.
    wait_ready();
    wr_valid = 1'b1;
    wr_x = 7'd30; wr_y = 6'd20; wr_op = 2'd1;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("b2b_ready%0d", i), {31'b0, wr_ready}, (i % 2));
      if (wr_ready && i < 5) exp_q.push_back(1'b0);
    end
    wr_valid = 1'b0;
    tick();

`ifdef FB_CLEAR_EN
    // clr_req together with a set: set completes, then a full clear.
    wait_ready();
    wr_valid = 1'b1; clr_req = 1'b1;
    wr_x = 7'd20; wr_y = 6'd10; wr_op = 2'd1;
    exp_q.push_back(1'b0);
    tick();
    wr_valid = 1'b0; clr_req = 1'b0;
    check("pend_exec_busy", {31'b0, busy}, 0);
    tick();
    check("pend_done", {31'b0, wr_done}, 1);
    check("pend_busy", {31'b0, busy}, 1);
    count_busy("pend_clear_len");
    rd_check("pend_cell_zero", 10'd160, 9'd80, 1'b1, 1'b0);
    rd_check("pend_other_zero", 10'd240, 9'd160, 1'b1, 1'b0);

    // clr_req during a clear does not restart it.
    do_cmd(7'd12, 6'd7, 2'd1, 1'b0);
    wait_ready();
    clr_req = 1'b1;
    tick();
    begin
      int cyc = 0;
      while (busy && cyc < 6000) begin
        clr_req = (cyc == 100);
        tick();
        cyc++;
      end
      clr_req = 1'b0;
      check("clr_ignore_len", cyc, 4800);
    end
    rd_check("clr_cell_zero", 10'd100, 9'd60, 1'b1, 1'b0);

    // Reset 100 cycles into a clear: clear restarts from scratch.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    check("mid_clear_busy", {31'b0, busy}, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_busy", {31'b0, busy}, 1);
    count_busy("rst2_clear_len");
`else
    // Without the clear engine clr_req does nothing.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick();
    check("noclr_busy", {31'b0, busy}, 0);
    check("noclr_ready", {31'b0, wr_ready}, 1);
    rd_check("noclr_cell", 10'd240, 9'd160, 1'b1, 1'b1);
`endif

    tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_framebuffer.md
# pixel_framebuffer

1-bit-per-cell framebuffer sitting on the memory side of the VGA scan-out timing generator. It answers the generator's pixel reads (`x`, `y`, `rdn` in; `px` out) from an 80×60 cell array, with each cell covering 8×8 screen pixels. It also accepts drawing commands from the machine core over a valid/ready write port. An optional clear engine wipes the whole array.

## Interface
Parameters:
- CELL_W, 80, cells per row
- CELL_H, 60, cell rows
- SCALE_SHIFT, 3, log2 of screen pixels per cell edge

Ports:
- clk_25mhz  in  1  pixel clock; the only clock.
- reset  in  1  synchronous, active-high.
- x  in  10  scan column, 0..639 when valid.
- y  in  9  scan row, 0..479 when valid.
- rdn  in  1  read enable from the scan-out generator.
- px  out  1  pixel value, registered.
- wr_valid  in  1  write command valid.
- wr_ready  out  1  write command accepted when high with wr_valid.
- wr_x  in  7  cell column.
- wr_y  in  6  cell row.
- wr_op  in  2  0=nop, 1=set, 2=clear, 3=toggle.
- wr_done  out  1  one-cycle pulse when a command completes.
- wr_collision  out  1  valid with wr_done.
- clr_req  in  1  request a full-array clear (pulse).
- busy  out  1  clear in progress.

## Operation
- Storage is CELL_W*CELL_H bits. Address = wr_y*CELL_W + wr_x, max 4799.
- Read port is independent of the write port. Cell = (y>>SCALE_SHIFT, x>>SCALE_SHIFT).
- px is 0 in any of these cases: rdn was low, x ≥ 640, or y ≥ 480.
- The FSM has three states: IDLE, EXEC, CLEAR.
- IDLE:
  - wr_ready=1.
  - On a handshake, latch address and op, read the old cell, go to EXEC.
  - On clr_req with no handshake, go to CLEAR.
  - If clr_req and a handshake occur together, the write wins and the clear request is latched pending.
- EXEC:
  - wr_ready=0.
  - Write the new value: set→1, clear→0, toggle→~old, nop→unchanged.
  - Go to CLEAR if a clear is pending, else IDLE.
  - wr_done and wr_collision are registered and pulse the cycle after EXEC.
- Collision rule: wr_collision=1 only for toggle with old=1; it is 0 for every other op.
- Out-of-range commands (wr_x ≥ 80 or wr_y ≥ 60) are accepted and complete normally, but cause no write and wr_collision=0.
- CLEAR:
  - wr_ready=0, busy=1.
  - A 13-bit counter writes 0 to addresses 0..4799, one per cycle, then the FSM returns to IDLE.
  - clr_req during CLEAR is ignored; the clear does not restart.
- Reset values: px=0, wr_done=0, wr_collision=0, pending clear cleared, counter=0.
  - Next state is CLEAR (busy=1) with FB_CLEAR_EN, IDLE (busy=0) without it.
  - wr_ready=0 while CLEAR is running.
- Reset asserted mid-EXEC or mid-CLEAR aborts the operation with no wr_done. Array contents are whatever was written before the abort.

## Timing
- Read latency is 1 cycle: inputs sampled at edge N give px valid in cycle N+1. The image therefore appears shifted right by one screen pixel; this is accepted.
- Write:
  - Handshake in cycle N, EXEC in cycle N+1; the array is updated at the end of N+1.
  - wr_done is high in cycle N+2, and wr_ready is high again in N+2.
  - Peak throughput is one command per 2 cycles.
  - A scan read issued in cycle N+2 or later sees the new value. A read hitting the same cell in N+1 returns the old value; there is no bypass.
- Clear:
  - Accepted in IDLE in cycle N; CLEAR occupies cycles N+1..N+4800.
  - busy falls and wr_ready rises in cycle N+4801.

## Configuration
- FB_CLEAR_EN defined:
  - The clear engine, pending latch and counter are built.
  - Reset triggers an automatic clear.
- Undefined:
  - No CLEAR state; clr_req is ignored and busy is tied 0.
  - Array contents after reset are undefined (FPGA init value is 0).
  - wr_ready=1 from the first cycle after reset.

## Test plan
- Reset with FB_CLEAR_EN → busy=1 for exactly 4800 cycles; wr_ready rises in cycle 4801; px=0 at all scan positions.
- Set (12,7), then read x=96..103, y=56..63 → px=1 one cycle after each sample; x=95 and x=104 → px=0.
- Toggle (12,7) twice → first wr_done has wr_collision=1 and cell becomes 0; second has wr_collision=0 and cell becomes 1; wr_done 2 cycles after each handshake.
- Back-to-back wr_valid → wr_ready deasserts in EXEC; handshakes spaced exactly 2 cycles apart.
- clr_req in the same cycle as a set → set completes with wr_done, then busy for 4800 cycles, then the cell reads 0.
- Reset asserted 100 cycles into a clear → no wr_done, busy restarts, full 4800-cycle clear.
- Command with wr_x=80 → wr_done, wr_collision=0, no cell changes.
- Read with rdn=0 or x=640 → px=0.
